pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the IF/ID

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and its debug monitor.
// The state encoding is visible outside the controller, so the values are fixed.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves dmem wait, taken branch,
// load-use and imem wait hazards, and keeps saturating stall/flush profiling counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W        = pipe_ctrl_pkg::REG_W,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WAIT_MAX     = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IFID_rs,
    input  logic [REG_W-1:0] IFID_rt,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             PCWrite,
    output logic             IFIDStall,
    output logic             IFIDFlush,
    output logic             IDEXStall,
    output logic             IDEXFlush,
    output logic             EXMEMStall,
    output logic             MEMWBBubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import pipe_ctrl_pkg::*;

    localparam int unsigned          WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0]    WAIT_LIM  = WAIT_W'(WAIT_MAX);
    localparam logic [1:0]           FL_RELOAD = 2'(FLUSH_CYCLES - 1);

    ctrl_state_e       r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
    logic [1:0]        r_fl_cnt, w_fl_nxt;
    logic              r_timeout, w_timeout_nxt;
    logic              w_load_use;
    logic              w_freeze;

    assign w_load_use = IDEX_MemRead && (IDEX_rt != '0) &&
                        ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));

    // In MEM_WAIT only dmem_ready ends the freeze; the request is already latched in EX/MEM.
    assign w_freeze = (r_state == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);

    always_comb begin
        PCWrite       = 1'b1;
        IFIDStall     = 1'b0;
        IFIDFlush     = 1'b0;
        IDEXStall     = 1'b0;
        IDEXFlush     = 1'b0;
        EXMEMStall    = 1'b0;
        MEMWBBubble   = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_fl_nxt      = r_fl_cnt;
        w_timeout_nxt = r_timeout;

        if (rst) begin
            PCWrite     = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXFlush   = 1'b1;
            MEMWBBubble = 1'b1;
        end else if (w_freeze) begin
            PCWrite     = 1'b0;
            IFIDStall   = 1'b1;
            IDEXStall   = 1'b1;
            EXMEMStall  = 1'b1;
            MEMWBBubble = 1'b1;
            w_state_nxt = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_wait_nxt = WAIT_W'(1);
            end else if (r_wait_cnt != WAIT_LIM) begin
                w_wait_nxt = r_wait_cnt + 1'b1;
            end
            if (w_wait_nxt == WAIT_LIM) begin
                w_timeout_nxt = 1'b1;
            end
        end else if (branch_taken) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = FLUSH;
                w_fl_nxt    = FL_RELOAD;
            end else begin
                w_state_nxt = RUN;
                w_fl_nxt    = 2'd0;
            end
        end else if (r_fl_cnt != 2'd0) begin
            // Either in FLUSH, or releasing from a dmem stall that interrupted one.
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            if (r_fl_cnt == 2'd1) begin
                w_state_nxt = RUN;
                w_fl_nxt    = 2'd0;
            end else begin
                w_state_nxt = FLUSH;
                w_fl_nxt    = r_fl_cnt - 2'd1;
            end
        end else begin
            w_state_nxt = RUN;
            if (w_load_use) begin
                PCWrite   = 1'b0;
                IFIDStall = 1'b1;
                IDEXFlush = 1'b1;
            end else if (!imem_ready) begin
                PCWrite   = 1'b0;
                IFIDFlush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_fl_cnt   <= 2'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_fl_cnt   <= w_fl_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign mem_timeout = r_timeout;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk (clk),
        .i_clr (rst),
        .i_inc (!PCWrite),
        .o_cnt (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .i_clk (clk),
        .i_clr (rst),
        .i_inc (IFIDFlush),
        .o_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl plus a short saturation sequence
// on a narrow sat_counter.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  IFID_rs, IFID_rt, IDEX_rt;
    logic        IDEX_MemRead, branch_taken, dmem_req, dmem_ready, imem_ready;
    logic        PCWrite, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush, EXMEMStall, MEMWBBubble;
    logic        mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    logic        sat_clr = 1'b1;
    logic        sat_inc = 1'b0;
    logic [2:0]  sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(
        .REG_W        (5),
        .FLUSH_CYCLES (2),
        .WAIT_MAX     (3),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IFID_rs      (IFID_rs),
        .IFID_rt      (IFID_rt),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_rt      (IDEX_rt),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .imem_ready   (imem_ready),
        .PCWrite      (PCWrite),
        .IFIDStall    (IFIDStall),
        .IFIDFlush    (IFIDFlush),
        .IDEXStall    (IDEXStall),
        .IDEXFlush    (IDEXFlush),
        .EXMEMStall   (EXMEMStall),
        .MEMWBBubble  (MEMWBBubble),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    sat_counter #(
        .CNT_W (3)
    ) u_sat (
        .i_clk (clk),
        .i_clr (sat_clr),
        .i_inc (sat_inc),
        .o_cnt (sat_cnt)
    );

    // Output bit order: {PCWrite, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush,
    //                    EXMEMStall, MEMWBBubble, mem_timeout}
    localparam logic [7:0] O_IDLE = 8'b1000_0000;
    localparam logic [7:0] O_RST  = 8'b0010_1010;
    localparam logic [7:0] O_LU   = 8'b0100_1000;
    localparam logic [7:0] O_BR   = 8'b1010_1000;
    localparam logic [7:0] O_FRZ  = 8'b0101_0110;
    localparam logic [7:0] O_IW   = 8'b0010_0000;
    localparam logic [7:0] O_T    = 8'b0000_0001;

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        mr;
        logic [4:0]  irt;
        logic        br;
        logic        dq;
        logic        dr;
        logic        ir;
        logic [7:0]  exp_out;
        logic [15:0] exp_sc;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input int rs, input int rt, input logic mr,
                                input int irt, input logic br, input logic dq, input logic dr,
                                input logic ir, input logic [7:0] e, input int sc, input int fc);
        vec_t v;
        v.rst = r;       v.rs = 5'(rs);   v.rt = 5'(rt);   v.mr = mr;
        v.irt = 5'(irt); v.br = br;       v.dq = dq;       v.dr = dr;
        v.ir = ir;       v.exp_out = e;   v.exp_sc = 16'(sc); v.exp_fc = 16'(fc);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst          = v.rst;
        IFID_rs      = v.rs;
        IFID_rt      = v.rt;
        IDEX_MemRead = v.mr;
        IDEX_rt      = v.irt;
        branch_taken = v.br;
        dmem_req     = v.dq;
        dmem_ready   = v.dr;
        imem_ready   = v.ir;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Reset and idle
        vq.push_back(mk(1, 1, 2, 0, 3, 0, 0, 1, 1, O_RST,  0, 0));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_IDLE, 0, 0));
        // Load-use on rs, then on rt; rt==0 and non-load cases stay idle
        vq.push_back(mk(0, 8, 2, 1, 8, 0, 0, 1, 1, O_LU,   0, 0));
        vq.push_back(mk(0, 8, 2, 0, 8, 0, 0, 1, 1, O_IDLE, 1, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1, O_IDLE, 1, 0));
        vq.push_back(mk(0, 1, 5, 1, 5, 0, 0, 1, 1, O_LU,   1, 0));
        vq.push_back(mk(0, 1, 5, 0, 5, 0, 0, 1, 1, O_IDLE, 2, 0));
        // Instruction-memory wait
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 0, O_IW,   2, 0));
        // Branch: two flush cycles
        vq.push_back(mk(0, 1, 2, 0, 3, 1, 0, 1, 1, O_BR,   3, 1));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_BR,   3, 2));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_IDLE, 3, 3));
        // dmem wait of 4 cycles; timeout sets when wait_cnt reaches 3
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 0, 1, O_FRZ,        3, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 0, 1, O_FRZ,        4, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 0, 1, O_FRZ,        5, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 0, 1, O_FRZ | O_T,  6, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 1, 1, O_IDLE | O_T, 7, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_IDLE | O_T, 7, 3));
        // Branch together with dmem stall: freeze first, flush at release
        vq.push_back(mk(0, 1, 2, 0, 3, 1, 1, 0, 1, O_FRZ | O_T,  7, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 1, 1, 0, 1, O_FRZ | O_T,  8, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 1, 1, 1, 1, O_BR | O_T,   9, 3));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_BR | O_T,   9, 4));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_IDLE | O_T, 9, 5));
        // Branch beats load-use; dmem stall inside FLUSH keeps the flush owed
        vq.push_back(mk(0, 8, 2, 1, 8, 1, 0, 1, 1, O_BR | O_T,   9, 5));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 0, 1, O_FRZ | O_T,  9, 6));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 1, 1, O_BR | O_T,  10, 6));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_IDLE | O_T, 10, 7));
        // Load-use beats imem wait
        vq.push_back(mk(0, 8, 2, 1, 8, 0, 0, 1, 0, O_LU | O_T,  10, 7));
        // Reset during MEM_WAIT
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 1, 0, 1, O_FRZ | O_T, 11, 7));
        vq.push_back(mk(1, 1, 2, 0, 3, 0, 1, 0, 1, O_RST | O_T, 12, 7));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 0, 1, O_IDLE,       0, 0));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_IDLE,       0, 0));
        // Back-to-back branches reload the flush count
        vq.push_back(mk(0, 1, 2, 0, 3, 1, 0, 1, 1, O_BR,   0, 0));
        vq.push_back(mk(0, 1, 2, 0, 3, 1, 0, 1, 1, O_BR,   0, 1));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_BR,   0, 2));
        vq.push_back(mk(0, 1, 2, 0, 3, 0, 0, 1, 1, O_IDLE, 0, 3));

        apply(vq[0]);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            @(negedge clk);
            check("ctrl", i, 32'({PCWrite, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush,
                                  EXMEMStall, MEMWBBubble, mem_timeout}),
                  32'(vq[i].exp_out));
            check("counters", i, {stall_cnt, flush_cnt}, {vq[i].exp_sc, vq[i].exp_fc});
            @(posedge clk);
            #1;
        end

        // Saturating counter: clear, count up, hold at all-ones, clear again
        sat_clr = 1'b1;
        sat_inc = 1'b0;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        check("sat_clr", 0, 32'(sat_cnt), 32'd0);
        sat_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sat_inc", 3, 32'(sat_cnt), 32'd3);
        repeat (4) @(posedge clk);
        #1;
        check("sat_top", 7, 32'(sat_cnt), 32'd7);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 10, 32'(sat_cnt), 32'd7);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        check("sat_clr", 1, 32'(sat_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
